riscv_ifq: RTL

RISCV_IFQ -- requirements
Module: riscv_ifq

---
 rtl/riscv_ifq.sv | 93 +++++++++
 1 files changed

// File: rtl/riscv_ifq.sv
// riscv_ifq: circular instruction queue between fetch and decode.
// Define RISCV_IFQ_PERF_EN to enable the fetch stall cycle counter.
module riscv_ifq #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ifu_vld,
  input  logic [31:0]                ifu_pc,
  input  logic [31:0]                ifu_instr,
  output logic                       ifu_rdy,
  input  logic                       flush,
  input  logic                       idu_rdy,
  output logic                       ifq_vld,
  output logic [31:0]                ifq_pc,
  output logic [31:0]                ifq_instr,
  output logic [$clog2(DEPTH):0]     ifq_count,
  output logic [31:0]                ifq_stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  entry_t          head_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign ifu_rdy   = (count != FULL);
  assign ifq_vld   = (count != '0);
  assign ifq_count = count;

  assign push = ifu_vld && ifu_rdy && !flush;
  assign pop  = ifq_vld && idu_rdy && !flush;

  // Head data is gated so decode sees zeros whenever nothing is valid.
  assign head_q    = mem[head];
  assign ifq_pc    = ifq_vld ? head_q.pc    : 32'h0;
  assign ifq_instr = ifq_vld ? head_q.instr : 32'h0;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[tail] <= '{pc: ifu_pc, instr: ifu_instr};
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= nxt(tail);
      if (pop)  head <= nxt(head);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef RISCV_IFQ_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (ifu_vld && !ifu_rdy && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign ifq_stall_cnt = stall_q;
`else
  assign ifq_stall_cnt = 32'h0;
`endif

endmodule
